// File: rtl/rgb_clk_mgr_pkg.sv
// rgb_clk_pkg: FSM state encoding and width constants shared by the clock manager files.
package rgb_clk_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN} state_t;
  localparam int CH_W = 3;
  localparam int LOSS_W = 8;
endpackage

// File: rtl/rgb_ce_div.sv
// rgb_ce_div: one clock-enable channel with a shadowed divisor applied at wrap, D=0 disables.
module rgb_ce_div #(
  parameter int DIV_W = 16,
  parameter int DIV_INIT = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_stb
);
  localparam logic [DIV_W-1:0] INIT = DIV_W'(DIV_INIT);
  logic [DIV_W-1:0] r_div, r_shadow, r_cnt;
  logic r_pend, r_stb, w_wrap, w_apply, w_now;
  assign w_wrap = i_en && r_div != '0 && r_cnt == r_div - 1'b1;
  assign w_apply = !i_en || r_div == '0 || w_wrap;
  // Writing zero takes effect at once so a channel can be stopped mid-period.
  assign w_now = w_apply || (i_wr && i_div == '0);
  assign o_stb = r_stb && i_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= INIT;
      r_shadow <= INIT;
      r_cnt <= '0;
      r_pend <= 1'b0;
      r_stb <= 1'b0;
    end else begin
      r_stb <= w_wrap;
      r_cnt <= w_now ? '0 : r_cnt + 1'b1;
      if (i_wr) begin
        r_shadow <= i_div;
        r_pend <= !w_now;
        if (w_now) r_div <= i_div;
      end else if (r_pend && w_apply) begin
        r_div <= r_shadow;
        r_pend <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/rgb_clk_mgr.sv
// rgb_clk_mgr: lock-qualified downstream reset plus N_CH clock-enable strobes.
// Define RGB_CLK_MGR_LOSS_CNT_EN to add the saturating lock-loss counter output loss_cnt.
module rgb_clk_mgr
  import rgb_clk_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int DIV_W = 16,
  parameter int LOCK_HOLD = 1024,
  parameter int DIV_INIT = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  input  logic             cfg_valid,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             rst_out,
  output logic [N_CH-1:0]  stb,
  output logic             locked_q
`ifdef RGB_CLK_MGR_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0] loss_cnt
`endif
);
  localparam int HOLD_W = $clog2(LOCK_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
  state_t r_state, w_next;
  logic r_sync, r_locked_q, r_rst_out, r_err, w_run, w_acc;
  logic [HOLD_W-1:0] r_hold;
  logic [N_CH-1:0] w_wr;
  assign cfg_ready = !rst;
  assign w_acc = cfg_valid && cfg_ready;
  assign w_run = r_state == RUN;
  assign cfg_err = r_err;
  assign rst_out = r_rst_out;
  assign locked_q = r_locked_q;
  always_comb begin
    w_next = !r_locked_q ? WAIT_LOCK :
             r_state == WAIT_LOCK ? HOLD :
             (r_state == HOLD && r_hold == HOLD_LAST) ? RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 1'b0;
      r_locked_q <= 1'b0;
      r_state <= WAIT_LOCK;
      r_hold <= '0;
      r_rst_out <= 1'b1;
      r_err <= 1'b0;
    end else begin
      r_sync <= locked;
      r_locked_q <= r_sync;
      r_state <= w_next;
      r_hold <= r_state == HOLD ? r_hold + 1'b1 : '0;
      // Registered from the next state so rst_out is low exactly while in RUN.
      r_rst_out <= w_next != RUN;
      r_err <= w_acc && 32'(cfg_ch) >= N_CH;
    end
  end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_wr[g] = w_acc && cfg_ch == CH_W'(g);
    rgb_ce_div #(.DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) u_div (
      .clk(clk), .rst(rst), .i_en(w_run), .i_wr(w_wr[g]), .i_div(cfg_div), .o_stb(stb[g])
    );
  end
`ifdef RGB_CLK_MGR_LOSS_CNT_EN
  logic [LOSS_W-1:0] r_loss;
  always_ff @(posedge clk) begin
    if (rst) r_loss <= '0;
    else if (w_run && w_next == WAIT_LOCK && r_loss != '1) r_loss <= r_loss + 1'b1;
  end
  assign loss_cnt = r_loss;
`endif
endmodule

// File: tb/tb_rgb_clk_mgr.sv
// tb_rgb_clk_mgr: directed scenarios for rgb_clk_mgr with LOCK_HOLD=16, N_CH=3, DIV_INIT=4.
module tb_rgb_clk_mgr;
  logic clk = 1'b0, rst, locked, cfg_valid, cfg_ready, cfg_err, rst_out, locked_q;
  logic [2:0] cfg_ch, stb;
  logic [15:0] cfg_div;
`ifdef RGB_CLK_MGR_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  rgb_clk_mgr #(.N_CH(3), .DIV_W(16), .LOCK_HOLD(16), .DIV_INIT(4)) dut (
    .clk(clk), .rst(rst), .locked(locked), .cfg_valid(cfg_valid), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_ready(cfg_ready), .cfg_err(cfg_err), .rst_out(rst_out),
    .stb(stb), .locked_q(locked_q)
`ifdef RGB_CLK_MGR_LOSS_CNT_EN
    , .loss_cnt(loss_cnt)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; locked = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    tick; tick;
    rst = 1'b0;
  endtask
  task automatic bring_up;
    locked = 1'b1;
    repeat (19) tick;
  endtask
  task automatic test_reset;
    int n;
    rst = 1'b1; locked = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    tick; tick;
    n_chk++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL reset_rst_out got %b want 1", rst_out); end
    n_chk++; if (stb !== 3'b000) begin n_fail++; $display("FAIL reset_stb got %b want 000", stb); end
    n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    n_chk++; if (locked_q !== 1'b0) begin n_fail++; $display("FAIL reset_locked_q got %b want 0", locked_q); end
    n_chk++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_ready got %b want 0", cfg_ready); end
    rst = 1'b0; locked = 1'b1;
    #1;
    n_chk++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_rst got %b want 1", cfg_ready); end
    n = 0;
    while (rst_out === 1'b1 && n < 100) begin tick; n++; end
    n_chk++; if (n !== 19) begin n_fail++; $display("FAIL lock_to_run_cycles got %0d want 19", n); end
    n_chk++; if (locked_q !== 1'b1) begin n_fail++; $display("FAIL locked_q_high got %b want 1", locked_q); end
    n = 0;
    while (stb[0] !== 1'b1 && n < 50) begin tick; n++; end
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL first_stb_cycles got %0d want 4", n); end
    n_chk++; if (stb !== 3'b111) begin n_fail++; $display("FAIL first_stb_all got %b want 111", stb); end
    tick;
    n_chk++; if (stb !== 3'b000) begin n_fail++; $display("FAIL stb_one_cycle got %b want 000", stb); end
    n = 1;
    while (stb[0] !== 1'b1 && n < 50) begin tick; n++; end
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL stb_period got %0d want 4", n); end
  endtask
  task automatic test_glitch;
    int n;
    do_reset;
    locked = 1'b1;
    repeat (11) tick;
    locked = 1'b0;
    tick;
    locked = 1'b1;
    tick;
    n = 13;
    n_chk++; if (locked_q !== 1'b0) begin n_fail++; $display("FAIL glitch_locked_q got %b want 0", locked_q); end
    while (rst_out === 1'b1 && n < 100) begin tick; n++; end
    n_chk++; if (n !== 31) begin n_fail++; $display("FAIL glitch_run_cycles got %0d want 31", n); end
  endtask
  task automatic test_cfg_div;
    logic [4:0] v0, v1;
    int c0, c1;
    do_reset;
    bring_up;
    tick; tick;
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd2;
    tick;
    cfg_valid = 1'b0;
    v0 = '0; v1 = '0;
    repeat (5) begin
      tick;
      v0 = {v0[3:0], stb[0]};
      v1 = {v1[3:0], stb[1]};
    end
    n_chk++; if (v1 !== 5'b10101) begin n_fail++; $display("FAIL div2_pattern got %b want 10101", v1); end
    n_chk++; if (v0 !== 5'b10001) begin n_fail++; $display("FAIL ch0_pattern got %b want 10001", v0); end
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd0;
    tick;
    cfg_valid = 1'b0;
    n_chk++; if (stb[1] !== 1'b0) begin n_fail++; $display("FAIL div0_stb1 got %b want 0", stb[1]); end
    c0 = 0; c1 = 0;
    repeat (8) begin
      tick;
      c0 += int'(stb[0]);
      c1 += int'(stb[1]);
    end
    n_chk++; if (c1 !== 0) begin n_fail++; $display("FAIL div0_count got %0d want 0", c1); end
    n_chk++; if (c0 !== 2) begin n_fail++; $display("FAIL ch0_count got %0d want 2", c0); end
  endtask
  task automatic test_bad_ch;
    int n, c2;
    cfg_valid = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd1;
    tick;
    cfg_valid = 1'b0;
    n_chk++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_pulse got %b want 1", cfg_err); end
    tick;
    n_chk++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear got %b want 0", cfg_err); end
    n = 0;
    while (stb[0] !== 1'b1 && n < 8) begin tick; n++; end
    n_chk++; if (stb[0] !== 1'b1) begin n_fail++; $display("FAIL badch_wait_stb0 got %b want 1", stb[0]); end
    tick;
    n = 1;
    while (stb[0] !== 1'b1 && n < 50) begin tick; n++; end
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL badch_period got %0d want 4", n); end
    n_chk++; if (stb !== 3'b101) begin n_fail++; $display("FAIL badch_stb got %b want 101", stb); end
    cfg_valid = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd1;
    tick;
    cfg_valid = 1'b0;
    n = 0;
    while (stb[2] !== 1'b1 && n < 8) begin tick; n++; end
    n_chk++; if (stb[2] !== 1'b1) begin n_fail++; $display("FAIL div1_wait got %b want 1", stb[2]); end
    c2 = 0;
    repeat (5) begin tick; c2 += int'(stb[2]); end
    n_chk++; if (c2 !== 5) begin n_fail++; $display("FAIL div1_every_cycle got %0d want 5", c2); end
  endtask
  task automatic test_loss;
    locked = 1'b0;
    tick; tick;
    n_chk++; if (rst_out !== 1'b0) begin n_fail++; $display("FAIL loss_still_run got %b want 0", rst_out); end
    n_chk++; if (stb[2] !== 1'b1) begin n_fail++; $display("FAIL loss_stb2_before got %b want 1", stb[2]); end
    tick;
    n_chk++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL loss_rst_out got %b want 1", rst_out); end
    n_chk++; if (stb !== 3'b000) begin n_fail++; $display("FAIL loss_stb got %b want 000", stb); end
`ifdef RGB_CLK_MGR_LOSS_CNT_EN
    n_chk++; if (loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_cnt_one got %0d want 1", loss_cnt); end
    repeat (256) begin
      locked = 1'b1;
      repeat (20) tick;
      locked = 1'b0;
      repeat (3) tick;
    end
    n_chk++; if (loss_cnt !== 8'd255) begin n_fail++; $display("FAIL loss_cnt_sat got %0d want 255", loss_cnt); end
`endif
  endtask
  task automatic test_rst_mid;
    int n;
    do_reset;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd2;
    tick;
    cfg_valid = 1'b0;
    bring_up;
    n = 0;
    while (stb[0] !== 1'b1 && n < 20) begin tick; n++; end
    n_chk++; if (stb[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait_stb got %b want 1", stb[0]); end
    rst = 1'b1;
    tick;
    n_chk++; if (stb !== 3'b000) begin n_fail++; $display("FAIL rstmid_stb got %b want 000", stb); end
    n_chk++; if (rst_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_rst_out got %b want 1", rst_out); end
    rst = 1'b0;
    bring_up;
    n_chk++; if (rst_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_relock got %b want 0", rst_out); end
    n = 0;
    while (stb[0] !== 1'b1 && n < 50) begin tick; n++; end
    n_chk++; if (n !== 4) begin n_fail++; $display("FAIL rstmid_div_init got %0d want 4", n); end
  endtask
  initial begin
    test_reset;
    test_glitch;
    test_cfg_div;
    test_bad_ch;
    test_loss;
    test_rst_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
